acc_bank: RTL and testbench

- Parametrised successor to the single 8-bit accumulator register.
- Holds N independently addressable accumulators of width W, a shared carry flag, and an in-block ALU (load/add/sub/adc/and/shift).
- Adds a D-deep save/restore stack for spilling and reloading the selected accumulator.
- Sits between the datapath ALU result bus and the register file, replacing the plain load-only accumulator.

---
 rtl/acc_bank.sv | 145 ++++++++++++++
 tb/tb_acc_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_bank.sv
// Bank of N accumulators sharing a carry flag and a small in-block ALU,
// with a D-deep LIFO for spilling and reloading {carry, accumulator}.
module acc_bank #(
  parameter int W = 8,
  parameter int N = 4,
  parameter int D = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 write_en_acc,
  input  logic [2:0]           Op,
  input  logic [$clog2(N)-1:0] Sel,
  input  logic [W-1:0]         DataIn,
  input  logic                 Save,
  input  logic                 Restore,
  output logic [W-1:0]         DataOut,
  output logic                 CarryOut,
  output logic                 Zero,
  output logic                 StackFull,
  output logic                 StackEmpty,
  output logic                 StackErr
);

  localparam int SW = $clog2(N);
  localparam int PW = $clog2(D + 1);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ADC  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  logic [W-1:0] acc_q [N];
  logic [W:0]   stack_q [D];
  logic [PW-1:0] sp_q, sp_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;

  logic [W-1:0] acc_sel;
  logic [W-1:0] alu_res;
  logic         alu_carry;
  logic [W:0]   sum_ext;
  logic [W:0]   stack_top;
  logic [W-1:0] acc_wdata_d;
  logic         acc_we;
  logic         full, empty;
  logic         push, pop, op_en;

  assign acc_sel = acc_q[Sel];

  // ALU: result and carry for the selected accumulator
  always_comb begin
    alu_res   = acc_sel;
    alu_carry = carry_q;
    sum_ext   = {1'b0, acc_sel} + {1'b0, DataIn}
              + {{W{1'b0}}, (Op == OP_ADC) & carry_q};
    case (Op)
      OP_NOP:  ;
      OP_LOAD: alu_res = DataIn;
      OP_ADD,
      OP_ADC:  {alu_carry, alu_res} = sum_ext;
      OP_SUB: begin
        alu_res   = acc_sel - DataIn;
        alu_carry = (acc_sel >= DataIn);
      end
      OP_AND:  alu_res = acc_sel & DataIn;
      OP_SHL: begin
        alu_carry = acc_sel[W-1];
        alu_res   = {acc_sel[W-2:0], 1'b0};
      end
      OP_SHR: begin
        alu_carry = acc_sel[0];
        alu_res   = {1'b0, acc_sel[W-1:1]};
      end
      default: ;
    endcase
  end

  // Stack control; Save+Restore together is a conflict that blocks both
  // but still lets the op run, while a lone Restore always blocks the op.
  always_comb begin
    full   = (sp_q == PW'(D));
    empty  = (sp_q == '0);
    push   = Save & ~Restore & ~full;
    pop    = Restore & ~Save & ~empty;
    op_en  = write_en_acc & ~(Restore & ~Save);
    err_d  = err_q | (Save & Restore) | (Save & ~Restore & full)
           | (Restore & ~Save & empty);
    sp_d   = sp_q;
    if (push) begin
      sp_d = sp_q + PW'(1);
    end else if (pop) begin
      sp_d = sp_q - PW'(1);
    end
    stack_top = '0;
    for (int i = 0; i < D; i++) begin
      if (sp_q == PW'(i + 1)) begin
        stack_top = stack_q[i];
      end
    end
    acc_we      = pop | op_en;
    acc_wdata_d = pop ? stack_top[W-1:0] : alu_res;
    carry_d     = pop ? stack_top[W] : (op_en ? alu_carry : carry_q);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      carry_q <= 1'b0;
      sp_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      carry_q <= carry_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      for (int i = 0; i < N; i++) begin
        if (acc_we && (Sel == SW'(i))) begin
          acc_q[i] <= acc_wdata_d;
        end
      end
    end
  end

  // Stack contents need no reset: the pointer alone defines what is valid
  always_ff @(posedge Clk) begin
    for (int i = 0; i < D; i++) begin
      if (!Reset && push && (sp_q == PW'(i))) begin
        stack_q[i] <= {carry_q, acc_sel};
      end
    end
  end

  assign DataOut    = acc_sel;
  assign Zero       = (acc_sel == '0);
  assign CarryOut   = carry_q;
  assign StackFull  = full;
  assign StackEmpty = empty;
  assign StackErr   = err_q;

endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: directed scenarios plus randomized
// traffic compared against an arithmetic reference model with a queue stack.
module tb_acc_bank;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int D    = 4;
  localparam int SW   = $clog2(N);
  localparam int MASK = (1 << W) - 1;

  localparam int NOP = 0, LOAD = 1, ADD = 2, SUB = 3, ADC = 4, ANDOP = 5, SHL = 6, SHR = 7;

  logic          Clk = 1'b0;
  logic          Reset, write_en_acc, Save, Restore;
  logic [2:0]    Op;
  logic [SW-1:0] Sel;
  logic [W-1:0]  DataIn;
  logic [W-1:0]  DataOut;
  logic          CarryOut, Zero, StackFull, StackEmpty, StackErr;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_acc [N];
  int m_c;
  int m_err;
  int m_stk [$];

  acc_bank #(.W(W), .N(N), .D(D)) dut (
    .Clk(Clk), .Reset(Reset), .write_en_acc(write_en_acc), .Op(Op),
    .Sel(Sel), .DataIn(DataIn), .Save(Save), .Restore(Restore),
    .DataOut(DataOut), .CarryOut(CarryOut), .Zero(Zero),
    .StackFull(StackFull), .StackEmpty(StackEmpty), .StackErr(StackErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_op(input int op, input int sel, input int b);
    int a, t;
    a = m_acc[sel];
    case (op)
      LOAD:  m_acc[sel] = b;
      ADD:   begin t = a + b;       m_acc[sel] = t & MASK; m_c = t >> W; end
      ADC:   begin t = a + b + m_c; m_acc[sel] = t & MASK; m_c = t >> W; end
      SUB:   begin m_c = (a >= b) ? 1 : 0; m_acc[sel] = (a - b) & MASK; end
      ANDOP: m_acc[sel] = a & b;
      SHL:   begin m_c = (a >> (W - 1)) & 1; m_acc[sel] = (a << 1) & MASK; end
      SHR:   begin m_c = a & 1; m_acc[sel] = a >> 1; end
      default: ;
    endcase
  endtask

  task automatic model_step(input bit rst, input bit we, input int op, input int sel,
                            input int din, input bit sv, input bit rs);
    int e;
    if (rst) begin
      for (int i = 0; i < N; i++) m_acc[i] = 0;
      m_c = 0;
      m_err = 0;
      m_stk.delete();
    end else if (sv && rs) begin
      m_err = 1;
      if (we) model_op(op, sel, din);
    end else if (rs) begin
      if (m_stk.size() == 0) begin
        m_err = 1;
      end else begin
        e = m_stk.pop_back();
        m_acc[sel] = e & MASK;
        m_c = e >> W;
      end
    end else begin
      if (sv) begin
        if (m_stk.size() == D) m_err = 1;
        else m_stk.push_back((m_c << W) | m_acc[sel]);
      end
      if (we) model_op(op, sel, din);
    end
  endtask

  task automatic check_outputs(input int sel);
    check("dout",  DataOut, m_acc[sel]);
    check("carry", CarryOut, m_c);
    check("zero",  Zero, (m_acc[sel] == 0) ? 1 : 0);
    check("full",  StackFull, (m_stk.size() == D) ? 1 : 0);
    check("empty", StackEmpty, (m_stk.size() == 0) ? 1 : 0);
    check("err",   StackErr, m_err);
  endtask

  task automatic cycle(input bit rst, input bit we, input int op, input int sel,
                       input int din, input bit sv, input bit rs);
    Reset = rst; write_en_acc = we; Op = op[2:0]; Sel = sel[SW-1:0];
    DataIn = din[W-1:0]; Save = sv; Restore = rs;
    model_step(rst, we, op, sel, din, sv, rs);
    @(posedge Clk);
    #1;
    Reset = 1'b0; write_en_acc = 1'b0; Save = 1'b0; Restore = 1'b0;
    $display("t=%0t rst=%0b we=%0b op=%0d sel=%0d din=%02h sv=%0b rs=%0b -> dout=%02h c=%0b z=%0b sp_full=%0b sp_empty=%0b err=%0b",
             $time, rst, we, op, sel, din[W-1:0], sv, rs, DataOut, CarryOut, Zero,
             StackFull, StackEmpty, StackErr);
    check_outputs(sel);
  endtask

  task automatic peek(input int sel);
    Sel = sel[SW-1:0];
    #1;
    check_outputs(sel);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; write_en_acc = 1'b0; Op = '0; Sel = '0; DataIn = '0;
    Save = 1'b0; Restore = 1'b0;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
    m_c = 0; m_err = 0;

    // reset, then every accumulator reads zero
    cycle(1, 0, NOP, 0, 0, 0, 0);
    for (int s = 0; s < N; s++) peek(s);
    check("rst_zero", Zero, 1);

    // Sel=1 add/adc with carry
    cycle(0, 1, LOAD, 1, 'hF0, 0, 0);
    cycle(0, 1, ADD,  1, 'h20, 0, 0);
    check("tp_add", DataOut, 'h10);
    check("tp_add_c", CarryOut, 1);
    cycle(0, 1, ADC,  1, 'h01, 0, 0);
    check("tp_adc", DataOut, 'h12);
    check("tp_adc_c", CarryOut, 0);
    peek(0);
    check("tp_acc0", DataOut, 0);

    // Sel=2 sub / shifts
    cycle(0, 1, LOAD, 2, 'h05, 0, 0);
    cycle(0, 1, SUB,  2, 'h05, 0, 0);
    check("tp_sub0", DataOut, 0);
    check("tp_sub0_c", CarryOut, 1);
    cycle(0, 1, SUB,  2, 'h01, 0, 0);
    check("tp_subb", DataOut, 'hFF);
    check("tp_subb_c", CarryOut, 0);
    cycle(0, 1, SHR,  2, 0, 0, 0);
    check("tp_shr", DataOut, 'h7F);
    check("tp_shr_c", CarryOut, 1);
    cycle(0, 1, SHL,  2, 0, 0, 0);
    check("tp_shl", DataOut, 'hFE);
    check("tp_shl_c", CarryOut, 0);

    // save alongside an op captures the pre-op value; restore moves it
    cycle(0, 1, LOAD, 0, 'h33, 0, 0);
    cycle(0, 1, ADD,  0, 'h01, 1, 0);
    check("tp_save_op", DataOut, 'h34);
    cycle(0, 1, LOAD, 3, 'h77, 0, 1);
    check("tp_move", DataOut, 'h33);
    check("tp_move_empty", StackEmpty, 1);

    // fill, overflow, LIFO drain, underflow
    for (int k = 0; k < D; k++) begin
      cycle(0, 1, LOAD, 1, 'h10 + k, 0, 0);
      cycle(0, 0, NOP, 1, 0, 1, 0);
    end
    check("tp_full", StackFull, 1);
    cycle(0, 0, NOP, 1, 0, 1, 0);
    check("tp_ovf_err", StackErr, 1);
    for (int k = D - 1; k >= 0; k--) begin
      cycle(0, 0, NOP, 2, 0, 0, 1);
      check("tp_lifo", DataOut, 'h10 + k);
    end
    cycle(0, 0, NOP, 2, 0, 0, 1);
    check("tp_unf_err", StackErr, 1);

    // save+restore conflict still performs the op; reset beats everything
    cycle(0, 1, LOAD, 1, 'hAA, 1, 1);
    check("tp_conflict", DataOut, 'hAA);
    cycle(1, 1, ADD, 1, 'h05, 1, 0);
    check("tp_rst_err", StackErr, 0);
    for (int s = 0; s < N; s++) peek(s);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), $urandom_range(0, N - 1), $urandom_range(0, MASK),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
